score_recorder: RTL

//  Records a note sequence into the score RAM that the playback address counter later reads.

---
 rtl/score_recorder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/score_recorder.sv
// Records a stream of 12-bit note codes into consecutive score RAM words from address 0.
// Each take ends with a 0x000 terminator, written on stop or when the RAM is full.
module score_recorder #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              note_valid,
    input  logic [DATA_W-1:0] note_data,
    output logic              note_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rec_len,
    output logic              full,
    output logic              busy,
    output logic              rec_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;

    // The last word is reserved for the terminator, so no note is ever written there.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;
    logic              wr_en_nxt_s;
    logic [ADDR_W-1:0] wr_addr_nxt_s;
    logic [DATA_W-1:0] wr_data_nxt_s;
    logic [ADDR_W-1:0] rec_len_nxt_s;
    logic              full_nxt_s;
    logic              rec_done_nxt_s;
    logic              at_last_s;
    logic              accept_s;

    assign at_last_s  = (ptr_r == LAST_ADDR);
    assign note_ready = (state_r == ST_REC) && !at_last_s;
    assign accept_s   = note_valid && note_ready;
    assign busy       = (state_r != ST_IDLE);

    // Next-state and next-output computation for the recorder FSM.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        wr_en_nxt_s    = 1'b0;
        wr_addr_nxt_s  = wr_addr;
        wr_data_nxt_s  = wr_data;
        rec_len_nxt_s  = rec_len;
        full_nxt_s     = full;
        rec_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s   = ST_REC;
                    ptr_nxt_s     = {ADDR_W{1'b0}};
                    rec_len_nxt_s = {ADDR_W{1'b0}};
                    full_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REC: begin
                if (start) begin
                    // Restart abandons the current take without a terminator.
                    ptr_nxt_s     = {ADDR_W{1'b0}};
                    rec_len_nxt_s = {ADDR_W{1'b0}};
                    full_nxt_s    = 1'b0;
                end else begin
                    // Zero notes are consumed but dropped, since 0x000 marks end of score.
                    if (accept_s && (note_data != {DATA_W{1'b0}})) begin
                        wr_en_nxt_s   = 1'b1;
                        wr_addr_nxt_s = ptr_r;
                        wr_data_nxt_s = note_data;
                        ptr_nxt_s     = ptr_r + ADDR_W'(1);
                    end else begin
                        ptr_nxt_s = ptr_r;
                    end
                    if (stop || at_last_s) begin
                        state_nxt_s = ST_TERM;
                    end else begin
                        state_nxt_s = ST_REC;
                    end
                    if (at_last_s) begin
                        full_nxt_s = 1'b1;
                    end else begin
                        full_nxt_s = full;
                    end
                end
            end
            ST_TERM: begin
                wr_en_nxt_s    = 1'b1;
                wr_addr_nxt_s  = ptr_r;
                wr_data_nxt_s  = {DATA_W{1'b0}};
                rec_len_nxt_s  = ptr_r;
                rec_done_nxt_s = 1'b1;
                state_nxt_s    = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered RAM-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {ADDR_W{1'b0}};
            wr_en    <= 1'b0;
            wr_addr  <= {ADDR_W{1'b0}};
            wr_data  <= {DATA_W{1'b0}};
            rec_len  <= {ADDR_W{1'b0}};
            full     <= 1'b0;
            rec_done <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            wr_en    <= wr_en_nxt_s;
            wr_addr  <= wr_addr_nxt_s;
            wr_data  <= wr_data_nxt_s;
            rec_len  <= rec_len_nxt_s;
            full     <= full_nxt_s;
            rec_done <= rec_done_nxt_s;
        end
    end

endmodule
